seg7_scan_reader: RTL and testbench
===================================

# seg7_scan_reader

Receive-side counterpart of the BCD-to-seven-segment drive path. It samples a multiplexed display bus (one-hot digit enable plus shared segment lines) and decodes each digit's segment pattern back to BCD. It assembles complete scan frames, qualifies them by frame-to-frame stability, and then publishes the recovered digit vector. It sits on the display side of the clock design, either as an in-system readback or as a bench-side monitor of the display driver.

## Interface
- NUM_DIGITS, 6: digits per scan frame (HH:MM:SS); legal range 2..8.
- STABLE_FRAMES, 2: consecutive identical valid frames required before publishing; legal range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- an  input  NUM_DIGITS  digit enable, active high, expected one-hot or all-zero during a blanking gap.
- seg  input  7  segment lines {g,f,e,d,c,b,a}, active high.
- digits  output  4*NUM_DIGITS  published BCD digits; digit i is at [4i+3:4i].
- frame_valid  output  1  one-cycle pulse when digits is written.
- frame_err  output  1  one-cycle pulse when a completed frame contains an undecodable pattern.
- sync_lost  output  1  one-cycle pulse on a scan-order violation or a multi-hot an.

## Operation
- Decode, with a = bit 0:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - 0x00 (blank, leading-zero suppression) decodes to 4'hF and is valid.
  - Any other pattern is invalid.
- Input registers an_q and seg_q capture an and seg every cycle.
- A visit is a maximal run of cycles in which an holds one constant one-hot value.
- A visit commits when an != an_q and an_q is one-hot. The committed pattern is seg_q, i.e. the last cycle of the visit.
- an returning to 0 counts as a change. Runs of all-zero an are ignored.
- FSM states:
  - SYNC: discard commits until a commit of digit 0, then store it in the frame buffer and go to COLLECT with expected index 1.
  - COLLECT:
    - A commit of the expected index is stored and the index increments.
    - A commit of any other index pulses sync_lost and goes to SYNC. If that index is 0, it is treated as a fresh frame start.
    - Committing index NUM_DIGITS-1 goes to CHECK.
  - CHECK: lasts one cycle, then returns to SYNC. A digit-0 commit that arrives during CHECK goes to COLLECT with expected index 1.
    - If any digit in the frame was invalid: pulse frame_err, clear the match count, leave digits unchanged.
    - Else if the frame equals the previous frame buffer: match count increments, saturating at STABLE_FRAMES.
    - Else: match count = 1.
    - Previous frame buffer ← current frame.
    - If match count ≥ STABLE_FRAMES: digits ← frame and pulse frame_valid.
- Multi-hot an in any state pulses sync_lost, discards the partial frame and goes to SYNC. The match count is preserved.

## Timing
- Reset values:
  - digits = all 4'hF.
  - frame_valid, frame_err and sync_lost = 0.
  - FSM in SYNC; match count 0; buffers all 4'hF; an_q = 0 and seg_q = 0.
- Latency: the last-digit visit ends at edge E (an changes). The commit happens at E+1, CHECK occupies E+2, and digits/frame_valid are visible after E+2.
- Minimum visit length is 1 cycle. There is no minimum gap between visits.
- With STABLE_FRAMES=1, every valid frame publishes.
- Reset asserted mid-frame aborts immediately with no pulse.

## Configuration
- SEG7_SCAN_READER_ERRCNT_EN
  - Defined: adds output err_count [7:0]. It is a saturating count (stops at 255) of frame_err plus sync_lost pulses, reset to 0. A cycle with both pulses adds 2.
  - Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package seg7_pkg holds:
  - the seven segment-pattern constants;
  - BLANK_CODE = 4'hF;
  - the FSM state enum {SYNC, COLLECT, CHECK}.
- One sub-module, seg7_decode: combinational, 7-bit pattern to {valid, bcd[3:0]}, instantiated once on seg_q.

## Test plan
- Scan 1,2,3,4,5,6 (digit 0 = 1), 4 cycles per visit, two frames, STABLE_FRAMES=2 → after the first frame no frame_valid; after the second frame digits = 0x654321 and a single frame_valid pulse.
- Same scan but digit 3 driven 0x49 → frame_err pulse on each frame, no frame_valid, digits stay at the reset value 0xFFFFFF.
- Visit order 0,1,3 → sync_lost pulse. A following clean pair of frames still publishes.
- an = 0x05 for one cycle mid-frame → sync_lost pulse and the partial frame is discarded.
- Digit 5 blank (seg = 0x00) → that digit publishes as F, no error.
- Reset asserted between visit 2 and visit 3 → all outputs return to reset values. Publishing then requires 2 fresh frames.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan readback path:
// segment patterns ({g,f,e,d,c,b,a}, a = bit 0), the blank code and the frame FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        SYNC,
        COLLECT,
        CHECK
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decoder; a blank pattern is a legal
// leading-zero-suppressed digit and decodes to BLANK_CODE.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       valid_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        valid_o = 1'b1;
        bcd_o   = BLANK_CODE;
        unique case (pattern_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: bcd_o = BLANK_CODE;
            default:   valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a multiplexed seven-segment bus, publishing only stable frames.
// Optional macro SEG7_SCAN_READER_ERRCNT_EN adds a saturating err_count output.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    sync_lost
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [DW-1:0] ALL_BLANK = {NUM_DIGITS{BLANK_CODE}};
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    MATCH_MAX = 4'(STABLE_FRAMES);

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    scan_state_e           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         cur_q, cur_d;
    logic [DW-1:0]         prev_q, prev_d;
    logic [DW-1:0]         digits_q, digits_d;
    logic                  bad_q, bad_d;
    logic [3:0]            match_q, match_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  sync_lost_q, sync_lost_d;

    logic          dec_valid;
    logic [3:0]    dec_bcd;
    logic          commit;
    logic          multi_hot;
    logic [IW-1:0] cidx;
    logic          start_frame;

    seg7_decode u_decode (
        .pattern_i (seg_q),
        .valid_o   (dec_valid),
        .bcd_o     (dec_bcd)
    );

    // A visit ends when an moves away from a one-hot value; seg_q is its last-cycle pattern.
    assign commit    = (an != an_q) && $onehot(an_q);
    assign multi_hot = !$onehot0(an_q);

    always_comb begin
        cidx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_q[i]) cidx = IW'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cur_d         = cur_q;
        prev_d        = prev_q;
        digits_d      = digits_q;
        bad_d         = bad_q;
        match_d       = match_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        sync_lost_d   = 1'b0;
        start_frame   = 1'b0;

        unique case (state_q)
            SYNC: begin
                if (commit && cidx == '0) start_frame = 1'b1;
            end
            COLLECT: begin
                if (commit) begin
                    if (cidx == idx_q) begin
                        cur_d[4*idx_q +: 4] = dec_bcd;
                        bad_d               = bad_q | !dec_valid;
                        if (idx_q == LAST_IDX) state_d = CHECK;
                        else                   idx_d   = idx_q + IW'(1);
                    end else begin
                        sync_lost_d = 1'b1;
                        state_d     = SYNC;
                        if (cidx == '0) start_frame = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = SYNC;
                if (bad_q) begin
                    frame_err_d = 1'b1;
                    match_d     = 4'd0;
                end else if (cur_q == prev_q) begin
                    if (match_q < MATCH_MAX) match_d = match_q + 4'd1;
                end else begin
                    match_d = 4'd1;
                end
                prev_d = cur_q;
                if (!bad_q && match_d >= MATCH_MAX) begin
                    digits_d      = cur_q;
                    frame_valid_d = 1'b1;
                end
                if (commit && cidx == '0) start_frame = 1'b1;
            end
            default: state_d = SYNC;
        endcase

        // A digit-0 commit opens a new frame; the frame being checked was already captured above.
        if (start_frame) begin
            cur_d[3:0] = dec_bcd;
            bad_d      = !dec_valid;
            idx_d      = IW'(1);
            state_d    = COLLECT;
        end

        if (multi_hot) begin
            sync_lost_d = 1'b1;
            state_d     = SYNC;
        end
    end

    // NOTE: frame buffers are reset because the first frame is compared against prev_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q          <= '0;
            seg_q         <= '0;
            state_q       <= SYNC;
            idx_q         <= '0;
            cur_q         <= ALL_BLANK;
            prev_q        <= ALL_BLANK;
            digits_q      <= ALL_BLANK;
            bad_q         <= 1'b0;
            match_q       <= 4'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            sync_lost_q   <= 1'b0;
        end else begin
            an_q          <= an;
            seg_q         <= seg;
            state_q       <= state_d;
            idx_q         <= idx_d;
            cur_q         <= cur_d;
            prev_q        <= prev_d;
            digits_q      <= digits_d;
            bad_q         <= bad_d;
            match_q       <= match_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            sync_lost_q   <= sync_lost_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign sync_lost   = sync_lost_q;

`ifdef SEG7_SCAN_READER_ERRCNT_EN
    logic [7:0] err_count_q;
    logic [8:0] err_sum;

    // Both pulses in one cycle add two; the count sticks at 255.
    assign err_sum = {1'b0, err_count_q} + 9'(frame_err_q) + 9'(sync_lost_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_count_q <= 8'd0;
        else       err_count_q <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: table of two-frame scans plus hand-built sequences
// for scan-order errors, multi-hot enables and mid-frame reset.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic [23:0] digits;
    logic        frame_valid;
    logic        frame_err;
    logic        sync_lost;
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int fe_cnt   = 0;
    int sl_cnt   = 0;

    seg7_scan_reader #(.NUM_DIGITS(6), .STABLE_FRAMES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sync_lost   (sync_lost)
`ifdef SEG7_SCAN_READER_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) fv_cnt++;
            if (frame_err)   fe_cnt++;
            if (sync_lost)   sl_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        fv_cnt = 0;
        fe_cnt = 0;
        sl_cnt = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        an    = '0;
        seg   = '0;
        step(3);
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic visit(input int idx, input logic [6:0] s, input int len);
        an      = '0;
        an[idx] = 1'b1;
        seg     = s;
        step(len);
    endtask

    task automatic gap(input int n);
        an  = '0;
        seg = '0;
        step(n);
    endtask

    task automatic scan_frame(input logic [41:0] segs, input int len);
        for (int i = 0; i < 6; i++) visit(i, segs[7*i +: 7], len);
    endtask

    typedef struct {
        string       name;
        logic [41:0] segs;
        int          len;
        int          gap1;
        logic [23:0] exp_digits;
        int          exp_fv;
        int          exp_fe;
    } vec_t;

    vec_t vecs[4];
    logic [41:0] clean;

    initial begin
        // digit i occupies segs[7i+6:7i]
        clean   = {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        vecs[0] = '{"count_up",  clean,                                               4, 4, 24'h654321, 1, 0};
        vecs[1] = '{"bad_d3",    {7'h7D, 7'h6D, 7'h49, 7'h4F, 7'h5B, 7'h06},           4, 4, 24'hFFFFFF, 0, 2};
        vecs[2] = '{"blank_d5",  {7'h00, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06},           3, 4, 24'hF54321, 1, 0};
        vecs[3] = '{"min_visit", {7'h7F, 7'h3F, 7'h6F, 7'h7F, 7'h07, 7'h3F},           1, 0, 24'h809870, 1, 0};

        // Reset values, checked while reset is held.
        reset = 1'b1;
        an    = '0;
        seg   = '0;
        step(2);
        check("rst_digits", 32'(digits), 32'hFFFFFF);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);
        check("rst_sl", 32'(sync_lost), 32'h0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            apply_reset();
            scan_frame(vecs[v].segs, vecs[v].len);
            gap(vecs[v].gap1);
            check({vecs[v].name, "_f1_fv"}, 32'(fv_cnt), 32'h0);
            scan_frame(vecs[v].segs, vecs[v].len);
            gap(4);
            check({vecs[v].name, "_digits"}, 32'(digits), 32'(vecs[v].exp_digits));
            check({vecs[v].name, "_fv"}, 32'(fv_cnt), 32'(vecs[v].exp_fv));
            check({vecs[v].name, "_fe"}, 32'(fe_cnt), 32'(vecs[v].exp_fe));
            check({vecs[v].name, "_sl"}, 32'(sl_cnt), 32'h0);
        end

        // Publish latency: commit one cycle after the last visit ends, CHECK the next, then visible.
        apply_reset();
        scan_frame(clean, 4);
        gap(4);
        scan_frame(clean, 4);
        an  = '0;
        seg = '0;
        step(1);
        check("lat_e1_fv", 32'(frame_valid), 32'h0);
        step(1);
        check("lat_e2_fv", 32'(frame_valid), 32'h1);
        check("lat_e2_digits", 32'(digits), 32'h654321);
        step(1);
        check("lat_e3_fv", 32'(frame_valid), 32'h0);

        // Scan order 0,1,3: one sync_lost, then a clean pair still publishes.
        apply_reset();
        visit(0, 7'h06, 4);
        visit(1, 7'h5B, 4);
        visit(3, 7'h66, 4);
        visit(4, 7'h6D, 4);
        visit(5, 7'h7D, 4);
        gap(4);
        check("order_sl", 32'(sl_cnt), 32'h1);
        check("order_no_fv", 32'(fv_cnt), 32'h0);
        scan_frame(clean, 4);
        gap(4);
        scan_frame(clean, 4);
        gap(4);
        check("order_recover_fv", 32'(fv_cnt), 32'h1);
        check("order_recover_digits", 32'(digits), 32'h654321);

        // Multi-hot mid-frame: partial frame dropped, match count kept.
        apply_reset();
        scan_frame(clean, 4);
        gap(4);
        visit(0, 7'h06, 4);
        visit(1, 7'h5B, 4);
        visit(2, 7'h4F, 4);
        an = 6'h05;
        step(1);
        visit(3, 7'h66, 4);
        visit(4, 7'h6D, 4);
        visit(5, 7'h7D, 4);
        gap(4);
        check("mhot_sl", 32'(sl_cnt), 32'h1);
        check("mhot_no_fv", 32'(fv_cnt), 32'h0);
        check("mhot_no_fe", 32'(fe_cnt), 32'h0);
        scan_frame(clean, 4);
        gap(4);
        check("mhot_kept_match_fv", 32'(fv_cnt), 32'h1);

        // Reset between visit 2 and visit 3 after a publish.
        check("prerst_digits", 32'(digits), 32'h654321);
        visit(0, 7'h06, 4);
        visit(1, 7'h5B, 4);
        visit(2, 7'h4F, 4);
        an    = '0;
        reset = 1'b1;
        #2;
        check("midrst_digits", 32'(digits), 32'hFFFFFF);
        check("midrst_fv", 32'(frame_valid), 32'h0);
        step(2);
        reset = 1'b0;
        clear_counts();
        scan_frame(clean, 4);
        gap(4);
        check("midrst_f1_fv", 32'(fv_cnt), 32'h0);
        check("midrst_f1_digits", 32'(digits), 32'hFFFFFF);
        scan_frame(clean, 4);
        gap(4);
        check("midrst_f2_fv", 32'(fv_cnt), 32'h1);
        check("midrst_f2_digits", 32'(digits), 32'h654321);
        check("midrst_sl", 32'(sl_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
